// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared widths, allocator FSM state and voice record type
//
// Contents:
//   NOTE_W, VEL_W   : MIDI note / velocity field widths
//   alloc_state_t   : allocator FSM states (IDLE accepts, APPLY resolves)
//   voice_t         : per-voice register record {gate, note, velocity}

package midi_pkg;

    localparam int NOTE_W = 7;
    localparam int VEL_W  = 7;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } alloc_state_t;

    typedef struct packed {
        logic              gate;
        logic [NOTE_W-1:0] note;
        logic [VEL_W-1:0]  velocity;
    } voice_t;

endpackage

// File: rtl/voice_lru.sv
// rtl/voice_lru.sv - least-recently-started rank tracker for the voice bank
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   promote_en   : move voice promote_idx to rank 0 this cycle
//   promote_idx  : voice being started or restarted
//   oldest_idx   : voice currently holding rank NUM_VOICES-1 (steal victim)
//
// Ranks are a permutation of 0..NUM_VOICES-1; rank 0 is the most recently
// started voice. Reset gives voice i rank i.

module voice_lru #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = $clog2(NUM_VOICES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             promote_en,
    input  logic [AGE_W-1:0] promote_idx,
    output logic [AGE_W-1:0] oldest_idx
);

    logic [AGE_W-1:0] rank [NUM_VOICES];
    logic [AGE_W-1:0] promote_rank;

    assign promote_rank = rank[promote_idx];

    // Every voice younger than the promoted one ages by one; the promoted
    // voice becomes the youngest. This keeps the ranks a permutation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                rank[i] <= AGE_W'(i);
            end
        end else if (promote_en) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (AGE_W'(i) == promote_idx) begin
                    rank[i] <= '0;
                end else if (rank[i] < promote_rank) begin
                    rank[i] <= rank[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        oldest_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (rank[i] == AGE_W'(NUM_VOICES - 1)) begin
                oldest_idx = AGE_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic note-to-voice allocator with LRU stealing
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   evt_valid/ready : note event handshake (one event per two cycles)
//   evt_on          : 1 = note-on, 0 = note-off (note-on velocity 0 = off)
//   evt_note        : MIDI note number
//   evt_velocity    : MIDI velocity
//   voice_gate      : per-voice key-down level
//   voice_note      : packed notes, voice i at [7i+6:7i]
//   voice_velocity  : packed velocities, same packing
//   voice_trig      : one-cycle pulse on the voice started/restarted
//   voice_stolen    : one-cycle pulse when a note-on steals a busy voice

module voice_allocator
    import midi_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = $clog2(NUM_VOICES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         evt_valid,
    output logic                         evt_ready,
    input  logic                         evt_on,
    input  logic [NOTE_W-1:0]            evt_note,
    input  logic [VEL_W-1:0]             evt_velocity,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES*VEL_W-1:0]  voice_velocity,
    output logic [NUM_VOICES-1:0]        voice_trig,
    output logic                         voice_stolen
);

    alloc_state_t              state;
    logic                      lat_on;
    logic [NOTE_W-1:0]         lat_note;
    logic [VEL_W-1:0]          lat_vel;
    voice_t [NUM_VOICES-1:0]   voices;

    logic                      match_found;
    logic [AGE_W-1:0]          match_idx;
    logic                      free_found;
    logic [AGE_W-1:0]          free_idx;
    logic [AGE_W-1:0]          oldest_idx;
    logic [AGE_W-1:0]          target_idx;
    logic                      promote_en;

    assign evt_ready = (state == IDLE);

    // Match only considers gated voices: a released voice keeps its note for
    // the envelope tail but is free for reuse.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (voices[i].gate && (voices[i].note == lat_note)) begin
                match_found = 1'b1;
                match_idx   = AGE_W'(i);
            end
            if (!voices[i].gate && !free_found) begin
                free_found = 1'b1;
                free_idx   = AGE_W'(i);
            end
        end
    end

    // Note-on priority: retrigger own voice, else lowest free, else oldest.
    assign target_idx = match_found ? match_idx :
                        free_found  ? free_idx  : oldest_idx;

    assign promote_en = (state == APPLY) && lat_on;

    voice_lru #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W)
    ) u_lru (
        .clk         (clk),
        .rst_n       (rst_n),
        .promote_en  (promote_en),
        .promote_idx (target_idx),
        .oldest_idx  (oldest_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lat_on       <= 1'b0;
            lat_note     <= '0;
            lat_vel      <= '0;
            voices       <= '0;
            voice_trig   <= '0;
            voice_stolen <= 1'b0;
        end else begin
            voice_trig   <= '0;
            voice_stolen <= 1'b0;
            case (state)
                IDLE: begin
                    if (evt_valid) begin
                        // Velocity-0 note-on folds into note-off here so
                        // APPLY only sees two kinds of event.
                        lat_on   <= evt_on && (evt_velocity != '0);
                        lat_note <= evt_note;
                        lat_vel  <= evt_velocity;
                        state    <= APPLY;
                    end
                end
                APPLY: begin
                    state <= IDLE;
                    if (lat_on) begin
                        voices[target_idx].gate     <= 1'b1;
                        voices[target_idx].note     <= lat_note;
                        voices[target_idx].velocity <= lat_vel;
                        voice_trig[target_idx]      <= 1'b1;
                        voice_stolen                <= !match_found && !free_found;
                    end else if (match_found) begin
                        voices[match_idx].gate <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        voice_gate     = '0;
        voice_note     = '0;
        voice_velocity = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_gate[i]                       = voices[i].gate;
            voice_note[i*NOTE_W +: NOTE_W]      = voices[i].note;
            voice_velocity[i*VEL_W +: VEL_W]    = voices[i].velocity;
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - scoreboard bench for voice_allocator

module tb_voice_allocator;

    localparam int NV = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          evt_valid = 1'b0;
    logic          evt_ready;
    logic          evt_on = 1'b0;
    logic [6:0]    evt_note = '0;
    logic [6:0]    evt_velocity = '0;
    logic [NV-1:0] voice_gate;
    logic [NV*7-1:0] voice_note;
    logic [NV*7-1:0] voice_velocity;
    logic [NV-1:0] voice_trig;
    logic          voice_stolen;

    always #10 clk = ~clk;

    voice_allocator #(.NUM_VOICES(NV)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_on         (evt_on),
        .evt_note       (evt_note),
        .evt_velocity   (evt_velocity),
        .voice_gate     (voice_gate),
        .voice_note     (voice_note),
        .voice_velocity (voice_velocity),
        .voice_trig     (voice_trig),
        .voice_stolen   (voice_stolen)
    );

    typedef struct packed {
        logic [NV-1:0]   gate;
        logic [NV*7-1:0] note;
        logic [NV*7-1:0] vel;
        logic [NV-1:0]   trig;
        logic            stolen;
    } exp_t;

    exp_t exp_q[$];
    int   m_gate[NV];
    int   m_note[NV];
    int   m_vel[NV];
    int   lru[$];      // lru[0] = most recently started voice
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        lru = {};
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 0;
            m_note[i] = 0;
            m_vel[i]  = 0;
            lru.push_back(i);
        end
    endtask

    task automatic promote(input int v);
        for (int k = 0; k < lru.size(); k++) begin
            if (lru[k] == v) begin
                lru.delete(k);
                break;
            end
        end
        lru.push_front(v);
    endtask

    task automatic model_event(input bit on, input int note, input int vel, output exp_t e);
        int hit = -1;
        int fr  = -1;
        int tgt;
        logic [NV-1:0] trig = '0;
        bit stl = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (m_gate[i] != 0 && m_note[i] == note) hit = i;
        end
        if (on && vel != 0) begin
            if (hit >= 0) begin
                tgt = hit;
            end else begin
                for (int i = 0; i < NV; i++) begin
                    if (m_gate[i] == 0 && fr < 0) fr = i;
                end
                if (fr >= 0) begin
                    tgt = fr;
                end else begin
                    tgt = lru[lru.size()-1];
                    stl = 1'b1;
                end
            end
            m_gate[tgt] = 1;
            m_note[tgt] = note;
            m_vel[tgt]  = vel;
            trig[tgt]   = 1'b1;
            promote(tgt);
        end else if (hit >= 0) begin
            m_gate[hit] = 0;
        end
        e = '0;
        for (int i = 0; i < NV; i++) begin
            e.gate[i]       = (m_gate[i] != 0);
            e.note[7*i +: 7] = 7'(m_note[i]);
            e.vel[7*i +: 7]  = 7'(m_vel[i]);
        end
        e.trig   = trig;
        e.stolen = stl;
    endtask

    // Call just after a posedge; returns just after the accepting edge.
    task automatic send(input bit on, input int note, input int vel);
        exp_t e;
        int waits = 0;
        evt_valid    = 1'b1;
        evt_on       = on;
        evt_note     = 7'(note);
        evt_velocity = 7'(vel);
        @(negedge clk);
        while (!evt_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!evt_ready) begin
            tests++;
            fails++;
            $display("FAIL handshake_timeout: evt_ready stayed %0b, required 1", evt_ready);
            evt_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_event(on, note, vel, e);
        exp_q.push_back(e);
        #1;
        evt_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        exp_q.delete();
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples on falling edges, tracks accepted events and compares
    // the post-APPLY outputs against the scoreboard.
    initial begin
        int   st;
        bit   clr;
        exp_t e;
        st  = 0;
        clr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                st  = 0;
                clr = 1'b0;
            end else begin
                if (clr) begin
                    check("trig_clear", 64'(voice_trig), 64'(0));
                    check("stolen_clear", 64'(voice_stolen), 64'(0));
                    clr = 1'b0;
                end
                if (st == 1) begin
                    check("ready_low_in_apply", 64'(evt_ready), 64'(0));
                    st = 2;
                end else if (st == 2) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL scoreboard_empty: output update with no expected entry");
                    end else begin
                        e = exp_q.pop_front();
                        check("gate", 64'(voice_gate), 64'(e.gate));
                        check("note", 64'(voice_note), 64'(e.note));
                        check("velocity", 64'(voice_velocity), 64'(e.vel));
                        check("trig", 64'(voice_trig), 64'(e.trig));
                        check("stolen", 64'(voice_stolen), 64'(e.stolen));
                    end
                    st  = 0;
                    clr = 1'b1;
                end
                if (evt_valid && evt_ready) st = 1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, note, vel;
        bit on;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_gate", 64'(voice_gate), 64'(0));
        check("rst_note", 64'(voice_note), 64'(0));
        check("rst_vel", 64'(voice_velocity), 64'(0));
        check("rst_trig", 64'(voice_trig), 64'(0));
        check("rst_stolen", 64'(voice_stolen), 64'(0));
        check("rst_ready", 64'(evt_ready), 64'(1));
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First note lands in voice0, two edges after acceptance.
        send(1'b1, 60, 100);
        check("t1_ready_low", 64'(evt_ready), 64'(0));
        check("t1_trig_pending", 64'(voice_trig), 64'(0));
        @(posedge clk); #1;
        check("t1_gate", 64'(voice_gate), 64'(4'b0001));
        check("t1_note", 64'(voice_note[6:0]), 64'(60));
        check("t1_vel", 64'(voice_velocity[6:0]), 64'(100));
        check("t1_trig", 64'(voice_trig), 64'(4'b0001));

        // Fill all voices, then steal the oldest.
        do_reset();
        send(1'b1, 60, 90);
        send(1'b1, 64, 90);
        send(1'b1, 67, 90);
        send(1'b1, 71, 90);
        send(1'b1, 72, 50);
        @(posedge clk); #1;
        check("t2_stolen", 64'(voice_stolen), 64'(1));
        check("t2_gate", 64'(voice_gate), 64'(4'b1111));
        check("t2_note0", 64'(voice_note[6:0]), 64'(72));
        check("t2_note_hi", 64'(voice_note[27:7]), 64'({7'd71, 7'd67, 7'd64}));
        check("t2_trig", 64'(voice_trig), 64'(4'b0001));

        // Repeated note retriggers its own voice with new velocity.
        do_reset();
        send(1'b1, 60, 100);
        send(1'b1, 60, 20);
        @(posedge clk); #1;
        check("t3_vel", 64'(voice_velocity[6:0]), 64'(20));
        check("t3_gate", 64'(voice_gate), 64'(4'b0001));
        check("t3_trig", 64'(voice_trig), 64'(4'b0001));

        // Velocity-0 note-on releases; released voice is lowest free.
        do_reset();
        send(1'b1, 60, 100);
        send(1'b1, 64, 100);
        send(1'b1, 60, 0);
        @(posedge clk); #1;
        check("t4_gate_off", 64'(voice_gate), 64'(4'b0010));
        check("t4_note_kept", 64'(voice_note[6:0]), 64'(60));
        check("t4_trig_off", 64'(voice_trig), 64'(0));
        send(1'b1, 70, 100);
        @(posedge clk); #1;
        check("t4_gate_reuse", 64'(voice_gate), 64'(4'b0011));
        check("t4_note_reuse", 64'(voice_note[13:0]), 64'({7'd64, 7'd70}));

        // Unmatched note-off changes nothing.
        send(1'b0, 50, 33);
        @(posedge clk); #1;
        check("t5_gate", 64'(voice_gate), 64'(4'b0011));
        check("t5_note", 64'(voice_note[13:0]), 64'({7'd64, 7'd70}));
        check("t5_vel", 64'(voice_velocity[13:0]), 64'({7'd100, 7'd100}));
        check("t5_trig", 64'(voice_trig), 64'(0));
        check("t5_stolen", 64'(voice_stolen), 64'(0));

        // Reset during APPLY discards the event.
        send(1'b1, 80, 90);
        rst_n = 1'b0;
        #1;
        check("t6_ready", 64'(evt_ready), 64'(1));
        check("t6_gate", 64'(voice_gate), 64'(0));
        check("t6_note", 64'(voice_note), 64'(0));
        check("t6_vel", 64'(voice_velocity), 64'(0));
        check("t6_trig", 64'(voice_trig), 64'(0));
        do_reset();

        // Randomized traffic over a narrow note range to force matches/steals.
        repeat (300) begin
            r    = int'($urandom_range(0, 99));
            note = 56 + int'($urandom_range(0, 9));
            vel  = int'($urandom_range(1, 127));
            on   = (r < 65);
            if (r < 8) vel = 0;
            send(on, note, vel);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
